// File: rtl/xrv1_wb_arb.sv
// xrv1_wb_arb: merges ALU and buffered LSU/MDU results into one registered register-file write port
module xrv1_wb_arb #(
    parameter int data_width_p    = 32,
    parameter int rf_addr_width_p = 5,
    parameter int fifo_depth_p    = 4,
    parameter int starve_limit_p  = 8
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              alu_v_i,
    input  logic [rf_addr_width_p-1:0]        alu_rd_addr_i,
    input  logic [data_width_p-1:0]           alu_data_i,
    output logic                              alu_stall_o,
    input  logic                              lsu_v_i,
    output logic                              lsu_ready_o,
    input  logic [rf_addr_width_p-1:0]        lsu_rd_addr_i,
    input  logic [data_width_p-1:0]           lsu_data_i,
    output logic                              rd_w_en_o,
    output logic [rf_addr_width_p-1:0]        rd_addr_o,
    output logic [data_width_p-1:0]           rd_data_o,
    output logic [$clog2(fifo_depth_p):0]     fifo_count_o,
    output logic                              busy_o
);
    localparam int ptr_w = $clog2(fifo_depth_p);
    localparam int cnt_w = ptr_w + 1;
    localparam int st_w  = $clog2(starve_limit_p + 1);
    localparam int ent_w = rf_addr_width_p + data_width_p;

    logic [ent_w-1:0]           mem [fifo_depth_p];
    logic [ptr_w-1:0]           wr_ptr, rd_ptr;
    logic [cnt_w-1:0]           count;
    logic [st_w-1:0]            starve;
    logic                       empty, acc, pop, byp, push, sel;
    logic [rf_addr_width_p-1:0] head_addr, sel_addr;
    logic [data_width_p-1:0]    head_data, sel_data;

    always_comb begin
        empty       = count == '0;
        lsu_ready_o = count < cnt_w'(fifo_depth_p);
        acc         = lsu_v_i && lsu_ready_o;
        pop         = !alu_v_i && !empty;
        byp         = !alu_v_i && empty && acc;
        push        = acc && !byp;
        sel         = alu_v_i || pop || byp;
        {head_addr, head_data} = mem[rd_ptr];
        sel_addr    = alu_v_i ? alu_rd_addr_i : pop ? head_addr : lsu_rd_addr_i;
        sel_data    = alu_v_i ? alu_data_i : pop ? head_data : lsu_data_i;
        alu_stall_o = starve == st_w'(starve_limit_p);
        fifo_count_o = count;
        busy_o      = !empty || rd_w_en_o;
    end

    always_ff @(posedge clk_i)
        if (push) mem[wr_ptr] <= {lsu_rd_addr_i, lsu_data_i};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            starve    <= '0;
            rd_w_en_o <= 1'b0;
            rd_addr_o <= '0;
            rd_data_o <= '0;
        end else begin
            wr_ptr    <= push ? wr_ptr + ptr_w'(1) : wr_ptr;
            rd_ptr    <= pop ? rd_ptr + ptr_w'(1) : rd_ptr;
            count     <= count + cnt_w'(push) - cnt_w'(pop);
            starve    <= (pop || empty) ? '0 : alu_stall_o ? starve : starve + st_w'(1);
            rd_w_en_o <= sel && (sel_addr != '0);
            if (sel) begin
                rd_addr_o <= sel_addr;
                rd_data_o <= sel_data;
            end
        end
    end

    // Upstream must not issue ALU results while stalled; the ALU would still win arbitration.
    a_no_alu_in_stall: assert property (@(posedge clk_i) disable iff (!rst_ni) !(alu_stall_o && alu_v_i));
endmodule

// File: tb/tb_xrv1_wb_arb.sv
// tb_xrv1_wb_arb: directed checks of arbitration, FIFO buffering, starvation stall, x0 drop and async reset
module tb_xrv1_wb_arb;
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b1;
    logic        alu_v_i = 1'b0;
    logic [4:0]  alu_rd_addr_i = '0;
    logic [31:0] alu_data_i = '0;
    logic        alu_stall_o;
    logic        lsu_v_i = 1'b0;
    logic        lsu_ready_o;
    logic [4:0]  lsu_rd_addr_i = '0;
    logic [31:0] lsu_data_i = '0;
    logic        rd_w_en_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_o;
    logic [2:0]  fifo_count_o;
    logic        busy_o;
    int          n_chk = 0;
    int          n_fail = 0;

    xrv1_wb_arb dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .alu_v_i(alu_v_i), .alu_rd_addr_i(alu_rd_addr_i), .alu_data_i(alu_data_i), .alu_stall_o(alu_stall_o),
        .lsu_v_i(lsu_v_i), .lsu_ready_o(lsu_ready_o), .lsu_rd_addr_i(lsu_rd_addr_i), .lsu_data_i(lsu_data_i),
        .rd_w_en_o(rd_w_en_o), .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o),
        .fifo_count_o(fifo_count_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic alu(input logic v, input logic [4:0] a, input logic [31:0] d);
        alu_v_i = v; alu_rd_addr_i = a; alu_data_i = d;
    endtask

    task automatic lsu(input logic v, input logic [4:0] a, input logic [31:0] d);
        lsu_v_i = v; lsu_rd_addr_i = a; lsu_data_i = d;
    endtask

    task automatic wr(input string tag, input logic en, input logic [4:0] a, input logic [31:0] d);
        chk({tag, "_wen"}, 64'(rd_w_en_o), 64'(en));
        chk({tag, "_addr"}, 64'(rd_addr_o), 64'(a));
        chk({tag, "_data"}, 64'(rd_data_o), 64'(d));
    endtask

    initial begin
        #2 rst_ni = 1'b0;
        #1;
        wr("rst", 1'b0, 5'd0, 32'h0);
        chk("rst_cnt", 64'(fifo_count_o), 64'd0);
        chk("rst_stall", 64'(alu_stall_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_ready", 64'(lsu_ready_o), 64'd1);
        tick();
        rst_ni = 1'b1;
        tick();

        alu(1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        wr("alu", 1'b1, 5'd5, 32'hDEADBEEF);
        chk("alu_busy", 64'(busy_o), 64'd1);
        alu(1'b0, 5'd0, 32'h0);

        lsu(1'b1, 5'd7, 32'h11);
        #1 chk("byp_ready", 64'(lsu_ready_o), 64'd1);
        tick();
        wr("byp", 1'b1, 5'd7, 32'h11);
        chk("byp_cnt", 64'(fifo_count_o), 64'd0);
        lsu(1'b0, 5'd0, 32'h0);
        tick();
        wr("hold", 1'b0, 5'd7, 32'h11);
        chk("idle_busy", 64'(busy_o), 64'd0);

        alu(1'b1, 5'd0, 32'h55);
        tick();
        wr("alu_x0", 1'b0, 5'd0, 32'h55);
        alu(1'b1, 5'd3, 32'h33);
        lsu(1'b1, 5'd0, 32'h66);
        tick();
        wr("alu_r3", 1'b1, 5'd3, 32'h33);
        chk("x0_push_cnt", 64'(fifo_count_o), 64'd1);
        alu(1'b0, 5'd0, 32'h0);
        lsu(1'b0, 5'd0, 32'h0);
        tick();
        wr("lsu_x0", 1'b0, 5'd0, 32'h66);
        chk("x0_pop_cnt", 64'(fifo_count_o), 64'd0);

        // Fill the FIFO behind a continuous ALU stream until the starvation stall engages.
        for (int i = 0; i < 4; i++) begin
            alu(1'b1, 5'd1, 32'h100 + 32'(i));
            lsu(1'b1, 5'(10 + i), 32'hA0 + 32'(i));
            #1 chk("fill_ready", 64'(lsu_ready_o), 64'd1);
            tick();
            chk("fill_cnt", 64'(fifo_count_o), 64'(i + 1));
        end
        wr("alu_stream", 1'b1, 5'd1, 32'h103);
        lsu(1'b1, 5'd14, 32'hA4);
        #1 chk("full_ready", 64'(lsu_ready_o), 64'd0);
        chk("pre_stall", 64'(alu_stall_o), 64'd0);
        for (int k = 0; k < 5; k++) begin
            alu(1'b1, 5'd1, 32'h200 + 32'(k));
            tick();
            chk("stall", 64'(alu_stall_o), 64'(k == 4));
            chk("full_cnt", 64'(fifo_count_o), 64'd4);
        end
        alu(1'b0, 5'd0, 32'h0);
        #1 chk("full_pop_ready", 64'(lsu_ready_o), 64'd0);
        tick();
        wr("drain0", 1'b1, 5'd10, 32'hA0);
        chk("drain0_cnt", 64'(fifo_count_o), 64'd3);
        chk("drain0_stall", 64'(alu_stall_o), 64'd0);
        tick();
        wr("drain1", 1'b1, 5'd11, 32'hA1);
        chk("pushpop_cnt", 64'(fifo_count_o), 64'd3);
        lsu(1'b0, 5'd0, 32'h0);
        for (int i = 2; i < 5; i++) begin
            tick();
            wr("drain", 1'b1, 5'(10 + i), 32'hA0 + 32'(i));
            chk("drain_cnt", 64'(fifo_count_o), 64'(4 - i));
        end
        tick();
        chk("drained_busy", 64'(busy_o), 64'd0);

        alu(1'b1, 5'd2, 32'h22);
        lsu(1'b1, 5'd20, 32'hC0);
        tick();
        lsu(1'b1, 5'd21, 32'hC1);
        tick();
        chk("pre_rst_cnt", 64'(fifo_count_o), 64'd2);
        chk("pre_rst_wen", 64'(rd_w_en_o), 64'd1);
        alu(1'b0, 5'd0, 32'h0);
        lsu(1'b0, 5'd0, 32'h0);
        #2 rst_ni = 1'b0;
        #1;
        wr("mid_rst", 1'b0, 5'd0, 32'h0);
        chk("mid_rst_cnt", 64'(fifo_count_o), 64'd0);
        chk("mid_rst_stall", 64'(alu_stall_o), 64'd0);
        chk("mid_rst_busy", 64'(busy_o), 64'd0);
        tick();
        chk("rst_hold_wen", 64'(rd_w_en_o), 64'd0);
        rst_ni = 1'b1;
        tick();
        chk("post_rst_wen", 64'(rd_w_en_o), 64'd0);
        chk("post_rst_cnt", 64'(fifo_count_o), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
